systolic_array: RTL and testbench
=================================

# systolic_array

DIM×DIM output-stationary grid of signed multiply-accumulate cells, sitting directly downstream of the A-side skew memory and the B-side weight memory in the matrix-multiply datapath. Each cycle it consumes one skewed column of A, entering at the left edge, and one skewed row of B, entering at the top edge. It forwards A operands rightward and B operands downward, one register per cell. Each cell accumulates its own element of C = A×B, and any row of C can be preloaded or read out through a row-select port.

## Interface
- BITS_AB, 8, width of signed A/B operands
- BITS_C, 16, width of signed accumulators and C data
- DIM, 8, array dimension (rows = columns)

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  synchronous active-low reset
- en  in  1  advance array: shift operands and accumulate
- WrEn  in  1  load Cin into accumulator row Crow
- A  in  signed [BITS_AB-1:0] × DIM  A[r] is left-edge operand for row r
- B  in  signed [BITS_AB-1:0] × DIM  B[c] is top-edge operand for column c
- Cin  in  signed [BITS_C-1:0] × DIM  preload data, Cin[c] → cell (Crow,c)
- Crow  in  [$clog2(DIM)-1:0]  row select for WrEn and Cout
- Cout  out  signed [BITS_C-1:0] × DIM  Cout[c] = accumulator of cell (Crow,c)

## Operation
- Each cell (r,c) holds three registers: a_reg (BITS_AB), b_reg (BITS_AB) and acc (BITS_C).
- Cell operand inputs:
  - a_in = A[r] if c==0, else a_reg of cell (r,c-1).
  - b_in = B[c] if r==0, else b_reg of cell (r-1,c).
- en=1, per cell, for rows not being written by WrEn:
  - a_reg←a_in and b_reg←b_in.
  - acc←acc + a_in*b_in.
- Arithmetic for the accumulate:
  - Full signed product is 2·BITS_AB bits, sign-extended or truncated to BITS_C.
  - Sum wraps modulo 2^BITS_C.
  - No saturation and no overflow flag.
- en=0: all a_reg, b_reg and acc hold, except acc writes from WrEn.
- WrEn=1: acc of every cell in row Crow ← Cin[c].
  - WrEn has priority over accumulation for that row only.
  - a_reg and b_reg of that row still shift when en=1.
  - Other rows behave per en.
- Cout is combinational from the acc registers of row Crow, with no read latency.
  - A write is visible on Cout the cycle after the WrEn edge.
- rst_n=0 at a clock edge clears every a_reg, b_reg and acc to 0.
  - Reset overrides en and WrEn.
  - Cout therefore reads 0 after reset for any Crow.

## Timing
- Feeding convention:
  - Row r of A is skewed by r cycles; B column c is skewed by c cycles. The upstream memories supply this skew.
  - Zeros fill the skew gaps.
- Operand path:
  - A element k of row r is at port A[r] on en-cycle k+r and reaches cell (r,c) on en-cycle k+r+c.
  - B[k][c] reaches cell (r,c) on the same cycle.
- Result timing:
  - The last product lands in cell (r,c) at the edge ending en-cycle DIM-1+r+c.
  - The full C is valid after 3·DIM-2 en cycles counted from the first operand cycle.
  - Only en-asserted cycles count; en gaps stall the whole array coherently.
- Mid-operation reset discards all partial sums and in-flight operands.
  - The next en cycle behaves as the first cycle of a new multiply.
- WrEn and en in the same cycle on row Crow: acc gets Cin; operands still advance.
- Crow changes take effect on Cout within the same cycle, combinationally.

## Test plan
- Reset: drive random A/B with en=1, then rst_n=0 for 1 cycle → all Cout rows read 0 for Crow=0..DIM-1; next cycle with A=B=0 → still 0.
- Identity multiply, DIM=8:
  - Stimulus: A = matrix with A[i][j]=i*8+j-32, B = identity, both skewed, 3·DIM-2 en cycles.
  - Required: every row's Cout equals the matching A row, e.g. row 0 = −32..−25.
- Stall:
  - Stimulus: same as the identity test, with en deasserted for 5 cycles at en-cycle 7; inputs change randomly during the stall.
  - Required: final C identical to the unstalled result; Cout is frozen during the stall.
- Preload/readout:
  - Stimulus: WrEn with Crow=3, Cin[c]=100+c, then a multiply of all-ones 8×8 A and B.
  - Required: row 3 = 108+c; other rows = 8.
- Wraparound: A and B all −128, 8-cycle accumulate → each acc = 8·16384 mod 65536 = 0; with 3 terms → 49152 − 65536 = −16384.
- Reset mid-multiply at en-cycle 10 → all zeros; a subsequent full multiply gives the correct C with no residue.

Source files
------------

// File: rtl/systolic_array.sv
// systolic_array
//   DIM x DIM output-stationary grid of signed multiply-accumulate cells.
//   A operands enter at the left edge and move one cell right per enabled
//   cycle. B operands enter at the top edge and move one cell down per enabled
//   cycle. Each cell (r,c) accumulates its own element of C = A x B.
//   One row of accumulators can be preloaded (WrEn) or read out (Cout)
//   through the Crow row select.
//
// Ports
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset, clears operands and accumulators
//   en     : advance the array (shift operands, accumulate)
//   WrEn   : load Cin into the accumulators of row Crow
//   A[r]   : left-edge operand for row r (signed BITS_AB)
//   B[c]   : top-edge operand for column c (signed BITS_AB)
//   Cin[c] : preload data for cell (Crow,c) (signed BITS_C)
//   Crow   : row select shared by WrEn and Cout
//   Cout[c]: combinational accumulator value of cell (Crow,c)
module systolic_array #(
    parameter int BITS_AB = 8,
    parameter int BITS_C  = 16,
    parameter int DIM     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      WrEn,
    input  logic signed [BITS_AB-1:0] A    [DIM],
    input  logic signed [BITS_AB-1:0] B    [DIM],
    input  logic signed [BITS_C-1:0]  Cin  [DIM],
    input  logic [$clog2(DIM)-1:0]    Crow,
    output logic signed [BITS_C-1:0]  Cout [DIM]
);

    localparam int ROW_W  = $clog2(DIM);
    localparam int PROD_W = 2 * BITS_AB;

    // Full-precision signed product, sign-extended (or truncated) to the
    // accumulator width, then added with wrap-around modulo 2^BITS_C.
    function automatic logic signed [BITS_C-1:0] mac_wrap(
        input logic signed [BITS_C-1:0]  acc,
        input logic signed [BITS_AB-1:0] a,
        input logic signed [BITS_AB-1:0] b
    );
        logic signed [PROD_W-1:0]   prod;
        logic [PROD_W+BITS_C-1:0]   prod_ext;
        prod     = PROD_W'(a) * PROD_W'(b);
        prod_ext = {{BITS_C{prod[PROD_W-1]}}, prod};
        return acc + $signed(prod_ext[BITS_C-1:0]);
    endfunction

    logic signed [BITS_AB-1:0] a_q   [DIM][DIM];
    logic signed [BITS_AB-1:0] a_d   [DIM][DIM];
    logic signed [BITS_AB-1:0] a_in  [DIM][DIM];
    logic signed [BITS_AB-1:0] b_q   [DIM][DIM];
    logic signed [BITS_AB-1:0] b_d   [DIM][DIM];
    logic signed [BITS_AB-1:0] b_in  [DIM][DIM];
    logic signed [BITS_C-1:0]  acc_q [DIM][DIM];
    logic signed [BITS_C-1:0]  acc_d [DIM][DIM];

    always_comb begin
        for (int r = 0; r < DIM; r++) begin
            for (int c = 0; c < DIM; c++) begin
                // Edge cells take the port operand; interior cells take the
                // registered operand of their left / upper neighbour. The
                // guarded index keeps the unused branch in range.
                a_in[r][c] = (c == 0) ? A[r] : a_q[r][(c == 0) ? 0 : c - 1];
                b_in[r][c] = (r == 0) ? B[c] : b_q[(r == 0) ? 0 : r - 1][c];

                a_d[r][c]   = en ? a_in[r][c] : a_q[r][c];
                b_d[r][c]   = en ? b_in[r][c] : b_q[r][c];
                acc_d[r][c] = acc_q[r][c];

                // A row write wins over accumulation for that row only;
                // its operands still shift with en.
                if (WrEn && (Crow == ROW_W'(r))) begin
                    acc_d[r][c] = Cin[c];
                end else if (en) begin
                    acc_d[r][c] = mac_wrap(acc_q[r][c], a_in[r][c], b_in[r][c]);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < DIM; r++) begin
                for (int c = 0; c < DIM; c++) begin
                    a_q[r][c]   <= '0;
                    b_q[r][c]   <= '0;
                    acc_q[r][c] <= '0;
                end
            end
        end else begin
            a_q   <= a_d;
            b_q   <= b_d;
            acc_q <= acc_d;
        end
    end

    // Readout has no latency: Crow selects a row of live accumulators.
    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            Cout[c] = acc_q[Crow][c];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb_systolic_array
//   Randomized bench for systolic_array. The reference model holds the A, B
//   and preload matrices and computes each accumulator directly as
//   preload + sum of A[r][k]*B[k][c] over the products that have arrived
//   after a given number of enabled cycles, wrapped to 16 bits.
module tb_systolic_array;

    localparam int BITS_AB = 8;
    localparam int BITS_C  = 16;
    localparam int DIM     = 8;
    localparam int RUN_LEN = 3 * DIM - 2;

    logic                      clk;
    logic                      rst_n;
    logic                      en;
    logic                      WrEn;
    logic signed [BITS_AB-1:0] A    [DIM];
    logic signed [BITS_AB-1:0] B    [DIM];
    logic signed [BITS_C-1:0]  Cin  [DIM];
    logic [$clog2(DIM)-1:0]    Crow;
    logic signed [BITS_C-1:0]  Cout [DIM];

    int am  [DIM][DIM];
    int bm  [DIM][DIM];
    int pre [DIM][DIM];

    int n_chk;
    int n_err;

    systolic_array #(
        .BITS_AB (BITS_AB),
        .BITS_C  (BITS_C),
        .DIM     (DIM)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .WrEn (WrEn),
        .A    (A),
        .B    (B),
        .Cin  (Cin),
        .Crow (Crow),
        .Cout (Cout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic signed [BITS_C-1:0] got,
                       input logic signed [BITS_C-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Accumulator of cell (r,c) after t enabled cycles of a skewed multiply:
    // product k lands at the edge ending en-cycle k+r+c.
    function automatic logic signed [BITS_C-1:0] model(input int r, input int c, input int t);
        int s;
        s = pre[r][c];
        for (int k = 0; k < DIM; k++) begin
            if (k + r + c < t) s += am[r][k] * bm[k][c];
        end
        return BITS_C'(s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int rnd8();
        return int'($urandom_range(255)) - 128;
    endfunction

    // Present the skewed column of A and row of B for enabled cycle t.
    task automatic drive_cycle(input int t);
        for (int i = 0; i < DIM; i++) begin
            if (t - i >= 0 && t - i < DIM) begin
                A[i] = BITS_AB'(am[i][t-i]);
                B[i] = BITS_AB'(bm[t-i][i]);
            end else begin
                A[i] = '0;
                B[i] = '0;
            end
        end
        en   = 1'b1;
        WrEn = 1'b0;
        tick();
    endtask

    task automatic check_all(input string tag, input int t);
        for (int r = 0; r < DIM; r++) begin
            Crow = 3'(r);
            #1;
            for (int c = 0; c < DIM; c++) chk(tag, Cout[c], model(r, c, t));
        end
    endtask

    task automatic check_zero(input string tag);
        for (int r = 0; r < DIM; r++) begin
            Crow = 3'(r);
            #1;
            for (int c = 0; c < DIM; c++) chk(tag, Cout[c], 16'sd0);
        end
    endtask

    // Write the model's preload matrix into the accumulators, array idle.
    task automatic preload();
        en   = 1'b0;
        WrEn = 1'b1;
        for (int r = 0; r < DIM; r++) begin
            Crow = 3'(r);
            for (int c = 0; c < DIM; c++) Cin[c] = BITS_C'(pre[r][c]);
            tick();
        end
        WrEn = 1'b0;
    endtask

    // Enabled cycles t_from..t_to-1, with an optional stall before cycle
    // stall_at during which inputs wander and Cout must stay frozen.
    task automatic run_mult(input int t_from, input int t_to, input int stall_at,
                            input int stall_len);
        for (int t = t_from; t < t_to; t++) begin
            if (t == stall_at) begin
                for (int s = 0; s < stall_len; s++) begin
                    en = 1'b0;
                    for (int i = 0; i < DIM; i++) begin
                        A[i] = BITS_AB'(rnd8());
                        B[i] = BITS_AB'(rnd8());
                    end
                    tick();
                    Crow = 3'($urandom_range(DIM - 1));
                    #1;
                    for (int c = 0; c < DIM; c++) chk("stall_frozen", Cout[c], model(int'(Crow), c, t));
                end
            end
            drive_cycle(t);
        end
    endtask

    task automatic clear_model();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c]  = 0;
                bm[r][c]  = 0;
                pre[r][c] = 0;
            end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        WrEn  = 1'b0;
        Crow  = '0;
        for (int i = 0; i < DIM; i++) begin
            A[i]   = '0;
            B[i]   = '0;
            Cin[i] = '0;
        end
        clear_model();
        tick();
        tick();
        rst_n = 1'b1;

        // Reset: scramble state with random operands, then reset for a cycle.
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < DIM; i++) begin
                A[i] = BITS_AB'(rnd8());
                B[i] = BITS_AB'(rnd8());
            end
            en = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        WrEn  = 1'b1;
        for (int i = 0; i < DIM; i++) Cin[i] = 16'sd1234;
        tick();
        rst_n = 1'b1;
        WrEn  = 1'b0;
        check_zero("reset");
        for (int i = 0; i < DIM; i++) begin
            A[i] = '0;
            B[i] = '0;
        end
        en = 1'b1;
        tick();
        check_zero("reset_zero_op");

        // Identity multiply.
        clear_model();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c] = r * 8 + c - 32;
                bm[r][c] = (r == c) ? 1 : 0;
            end
        preload();
        run_mult(0, 10, -1, 0);
        check_all("ident_partial", 10);
        run_mult(10, RUN_LEN, -1, 0);
        check_all("ident", RUN_LEN);
        Crow = 3'd0;
        #1;
        chk("ident_row0_c0", Cout[0], -16'sd32);
        chk("ident_row0_c7", Cout[7], -16'sd25);

        // Same multiply with a 5-cycle stall at en-cycle 7.
        preload();
        run_mult(0, RUN_LEN, 7, 5);
        check_all("stall", RUN_LEN);

        // Preload row 3, then all-ones multiply.
        clear_model();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c] = 1;
                bm[r][c] = 1;
            end
        for (int c = 0; c < DIM; c++) pre[3][c] = 100 + c;
        preload();
        run_mult(0, RUN_LEN, -1, 0);
        check_all("preload", RUN_LEN);
        Crow = 3'd3;
        #1;
        chk("preload_row3_c0", Cout[0], 16'sd108);
        chk("preload_row3_c7", Cout[7], 16'sd115);
        Crow = 3'd5;
        #1;
        chk("preload_row5_c2", Cout[2], 16'sd8);

        // Wraparound with -128 operands.
        clear_model();
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c] = -128;
                bm[r][c] = -128;
            end
        preload();
        run_mult(0, 3, -1, 0);
        Crow = 3'd0;
        #1;
        chk("wrap_3terms", Cout[0], -16'sd16384);
        check_all("wrap_partial", 3);
        run_mult(3, RUN_LEN, -1, 0);
        check_all("wrap_full", RUN_LEN);

        // Random multiply with a random preload and a random stall.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c]  = rnd8();
                bm[r][c]  = rnd8();
                pre[r][c] = int'($urandom_range(65535)) - 32768;
            end
        preload();
        run_mult(0, RUN_LEN, int'($urandom_range(RUN_LEN - 1)), 3);
        check_all("random", RUN_LEN);

        // Reset in the middle of a multiply, then a clean multiply.
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c]  = rnd8();
                bm[r][c]  = rnd8();
                pre[r][c] = 0;
            end
        run_mult(0, 10, -1, 0);
        rst_n = 1'b0;
        en    = 1'b1;
        tick();
        rst_n = 1'b1;
        check_zero("mid_reset");
        for (int r = 0; r < DIM; r++)
            for (int c = 0; c < DIM; c++) begin
                am[r][c] = rnd8();
                bm[r][c] = rnd8();
            end
        run_mult(0, RUN_LEN, -1, 0);
        check_all("after_reset", RUN_LEN);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
